// File: rtl/pc_sequencer.sv
// pc_sequencer: fetches the word at pc, decodes its sequencing field and pulses inc/add/sub to the PC.
// Zero-wait memory gives FETCH/EXEC/SETTLE = 3 cycles per instruction; HALT and ERROR hold until reset.
module pc_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        flag,
  input  logic [15:0] pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        inc,
  output logic        add,
  output logic        sub,
  output logic [15:0] offset,
  output logic [15:0] instr,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_SETTLE, S_HALT, S_ERROR
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_wait, w_wait_next;
  logic [15:0] r_instr, w_instr_next;
  logic [1:0]  w_op;
  logic        w_cond;
  logic [15:0] w_imm;

  assign w_op   = r_instr[15:14];
  assign w_cond = r_instr[13];
  assign w_imm  = {3'b000, r_instr[12:0]};
  assign instr  = r_instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wait  <= 8'd0;
      r_instr <= 16'h0000;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      r_instr <= w_instr_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_wait_next  = r_wait;
    w_instr_next = r_instr;
    imem_req     = 1'b0;
    imem_addr    = 16'h0000;
    inc          = 1'b0;
    add          = 1'b0;
    sub          = 1'b0;
    offset       = 16'h0000;
    halted       = 1'b0;
    err          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        if (imem_ack) begin
          w_instr_next = imem_data;
          w_wait_next  = 8'd0;
          w_next       = S_EXEC;
        end else if (r_wait == TO_LAST) begin
          w_wait_next = 8'd0;
          w_next      = S_ERROR;
        end else begin
          w_wait_next = r_wait + 8'd1;
        end
      end
      S_EXEC: begin
        w_next = S_SETTLE;
        case (w_op)
          2'b00: inc = 1'b1;
          2'b01, 2'b10: begin
            // An untaken conditional branch falls through to the next word.
            if (w_cond && !flag) begin
              inc = 1'b1;
            end else begin
              add    = (w_op == 2'b01);
              sub    = (w_op == 2'b10);
              offset = w_imm;
            end
          end
          default: w_next = S_HALT;
        endcase
      end
      S_SETTLE: begin
        w_next = run ? S_FETCH : S_IDLE;
      end
      S_HALT:  halted = 1'b1;
      S_ERROR: err    = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a PC register, a latency-programmable memory and an instruction-level
// reference model compared every cycle, plus directed scenarios with literal expectations.
module tb_pc_sequencer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, run, flag;
  logic [15:0] pc;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_data;
  logic        inc, add, sub, halted, err;
  logic [15:0] offset, instr;

  logic        pc_ld;
  logic [15:0] pc_ld_val;
  logic        ack_en;
  int          mem_lat;
  int          mem_cnt;
  logic [15:0] mem [0:65535];
  int          cyc;
  int          tests = 0;
  int          fails = 0;
  bit          mdl_on = 1'b0;

  pc_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .run(run), .flag(flag), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .inc(inc), .add(add), .sub(sub), .offset(offset), .instr(instr),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  // The PC the sequencer commands.
  always @(posedge clk) begin
    if (pc_ld)    pc <= pc_ld_val;
    else if (inc) pc <= pc + 16'd1;
    else if (add) pc <= pc + offset;
    else if (sub) pc <= pc - offset;
  end

  // Memory acknowledges after mem_lat wait cycles of a held request.
  always @(posedge clk) mem_cnt <= imem_req ? mem_cnt + 1 : 0;
  assign imem_ack  = imem_req && ack_en && (mem_cnt >= mem_lat);
  assign imem_data = mem[imem_addr];

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        i, a, s;
    logic [15:0] off;
  } cmd_t;

  // Command an executed word must produce: the PC move its sequencing field asks for.
  function automatic cmd_t decode(input logic [15:0] w, input logic f);
    cmd_t c;
    c = '0;
    case (w[15:14])
      2'd0: c.i = 1'b1;
      2'd1, 2'd2: begin
        if (w[13] && !f) c.i = 1'b1;
        else begin
          c.a   = (w[15:14] == 2'd1);
          c.s   = (w[15:14] == 2'd2);
          c.off = {3'b000, w[12:0]};
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Phase of the current instruction: 0 idle, 1 fetching, 2 executing, 3 settling, 4 halted, 5 failed fetch.
  int          m_phase = 0;
  int          m_waits = 0;
  logic [15:0] m_instr = 16'h0;
  cmd_t        m_exp;

  always @(negedge clk) begin
    if (mdl_on) begin
      m_exp = (m_phase == 2) ? decode(m_instr, flag) : '0;
      check("req",    imem_req,  m_phase == 1);
      check("addr",   imem_addr, (m_phase == 1) ? pc : 16'h0);
      check("inc",    inc,       m_exp.i);
      check("add",    add,       m_exp.a);
      check("sub",    sub,       m_exp.s);
      check("offset", offset,    m_exp.off);
      check("halted", halted,    m_phase == 4);
      check("err",    err,       m_phase == 5);
      check("instr",  instr,     m_instr);
    end
    if (reset) begin
      m_phase = 0;
      m_waits = 0;
      m_instr = 16'h0;
    end else begin
      case (m_phase)
        0: if (run) m_phase = 1;
        1: begin
          if (imem_ack) begin
            m_instr = imem_data;
            m_waits = 0;
            m_phase = 2;
          end else begin
            m_waits++;
            if (m_waits == TO) m_phase = 5;
          end
        end
        2: m_phase = (m_instr[15:14] == 2'd3) ? 4 : 3;
        3: m_phase = run ? 1 : 0;
        default: ;
      endcase
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit sig_hit(input int k);
    case (k)
      0:       return imem_req;
      1:       return add;
      2:       return sub;
      3:       return inc | add | sub;
      default: return halted;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int k, input int max);
    int i;
    i = 0;
    while (i < max && !sig_hit(k)) begin
      step(1);
      i++;
    end
    check(nm, sig_hit(k), 1'b1);
  endtask

  task automatic do_reset(input logic [15:0] v);
    reset = 1'b1; pc_ld = 1'b1; pc_ld_val = v;
    step(2);
    reset = 1'b0; pc_ld = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_req"}, imem_req, 0);
    check({nm, "_addr"}, imem_addr, 0);
    check({nm, "_pulse"}, {inc, add, sub}, 0);
    check({nm, "_offset"}, offset, 0);
    check({nm, "_instr"}, instr, 0);
    check({nm, "_status"}, {halted, err}, 0);
  endtask

  initial begin
    int q[$];
    int n;
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    reset = 1'b1; run = 1'b0; flag = 1'b0; ack_en = 1'b1; mem_lat = 0;
    pc_ld = 1'b1; pc_ld_val = 16'h0;

    // Zero-wait sequential words: inc at cycles 2, 5, 8 and pc 0 -> 3.
    run = 1'b1;
    do_reset(16'h0000);
    mdl_on = 1'b1;
    check_all_zero("rst0");
    for (int c = 0; c < 11; c++) begin
      if (inc) q.push_back(cyc);
      if (c == 8) run = 1'b0;
      step(1);
    end
    check("inc_count", q.size(), 3);
    if (q.size() == 3) begin
      check("inc_cyc0", q[0], 2);
      check("inc_cyc1", q[1], 5);
      check("inc_cyc2", q[2], 8);
    end
    check("pc_after3", pc, 16'h0003);
    check("idle_after3", imem_req, 0);

    // Forward branch 0x4005 at 0x0010, resume at 0x0015.
    run = 1'b0;
    mem[16'h0010] = 16'h4005;
    do_reset(16'h0010);
    run = 1'b1;
    wait_for("add_seen", 1, 10);
    check("add_off", offset, 16'h0005);
    run = 1'b0;
    step(4);
    check("pc_fwd", pc, 16'h0015);
    check("no_req_idle", imem_req, 0);
    run = 1'b1;
    wait_for("req_resume", 0, 5);
    check("addr_fwd", imem_addr, 16'h0015);
    run = 1'b0;
    step(6);

    // Conditional forward branch, untaken then taken.
    mem[16'h0020] = 16'h6003;
    flag = 1'b0;
    do_reset(16'h0020);
    run = 1'b1;
    wait_for("cond_pulse0", 3, 10);
    check("cond_untaken", {inc, add, sub}, 3'b100);
    check("cond_untaken_off", offset, 16'h0);
    run = 1'b0;
    step(4);
    check("pc_untaken", pc, 16'h0021);
    flag = 1'b1;
    do_reset(16'h0020);
    run = 1'b1;
    wait_for("cond_pulse1", 3, 10);
    check("cond_taken", {inc, add, sub}, 3'b010);
    check("cond_taken_off", offset, 16'h0003);
    run = 1'b0;
    step(4);
    check("pc_taken", pc, 16'h0023);

    // Backward branch wrapping to 0xFFFF, then halt.
    flag = 1'b0;
    mem[16'h0001] = 16'h8002;
    mem[16'hFFFF] = 16'hC000;
    do_reset(16'h0001);
    run = 1'b1;
    wait_for("sub_seen", 2, 10);
    check("sub_off", offset, 16'h0002);
    wait_for("req_wrap", 0, 5);
    check("addr_wrap", imem_addr, 16'hFFFF);
    wait_for("halt_seen", 4, 10);
    for (int c = 0; c < 5; c++) begin
      check("halt_no_req", imem_req, 0);
      check("halt_sticky", halted, 1);
      step(1);
    end
    run = 1'b0;
    do_reset(16'h0000);
    check_all_zero("rst_halt");

    // Fetch timeout: request held exactly TO cycles, then ERROR.
    ack_en = 1'b0;
    do_reset(16'h0050);
    run = 1'b1;
    wait_for("req_to", 0, 5);
    n = 0;
    while (imem_req && n < 50) begin
      n++;
      step(1);
    end
    check("req_len", n, TO);
    check("err_set", err, 1);
    check("err_no_req", imem_req, 0);
    step(3);
    check("err_sticky", err, 1);

    // Reset while fetching drops the request.
    do_reset(16'h0060);
    step(2);
    check("mid_fetch", imem_req, 1);
    reset = 1'b1; run = 1'b0;
    step(1);
    reset = 1'b0;
    check_all_zero("rst_fetch");

    // run dropped mid-fetch with 2 wait cycles: instruction still completes.
    ack_en = 1'b1; mem_lat = 2;
    mem[16'h0040] = 16'h4003;
    do_reset(16'h0040);
    run = 1'b1;
    wait_for("req_slow", 0, 5);
    step(1);
    run = 1'b0;
    wait_for("add_slow", 1, 10);
    check("add_slow_off", offset, 16'h0003);
    for (int c = 0; c < 5; c++) begin
      step(1);
      check("stop_no_req", imem_req, 0);
    end
    check("pc_slow", pc, 16'h0043);
    run = 1'b1;
    wait_for("req_new_pc", 0, 5);
    check("addr_new_pc", imem_addr, 16'h0043);
    run = 1'b0;
    step(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
